// File: rtl/field_update_engine.sv
// field_update_engine: applies queued bit-field writes (lsb, len, data) to a
// WIDTH-bit held register with read-modify-write semantics, i.e.
// value[lsb +: len+1] = data, dropping any bits that land above WIDTH-1.
// Requests enter a 2-deep FIFO; a two-state FSM pops one request (IDLE) and
// commits it on the following edge (APPLY), so throughput is one per 2 cycles.
// Optional build macro FIELD_UPDATE_TRACE_EN: prints "===> %x" of the new value
// on every commit that changes the register (simulation only).
module field_update_engine #(
  parameter int                 WIDTH     = 8,
  parameter int                 LSBW      = 3,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [LSBW-1:0]  req_lsb,
  input  logic [LSBW-1:0]  req_len,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] value,
  output logic             changed,
  output logic             err,
  output logic             busy
);

  // Update arithmetic is carried out wide enough that a full-width field
  // shifted to the top bit cannot wrap before truncation.
  localparam int EW = WIDTH + LSBW + 1;

  typedef enum logic {IDLE, APPLY} state_t;

  state_t state_reg, state_next;

  // Request FIFO storage (no reset needed; guarded by count)
  logic [LSBW-1:0]  fifo_lsb  [2];
  logic [LSBW-1:0]  fifo_len  [2];
  logic [WIDTH-1:0] fifo_data [2];
  logic             wr_ptr_reg, rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             push, pop;

  // Request being applied
  logic [LSBW-1:0]  apply_lsb_reg, apply_len_reg;
  logic [WIDTH-1:0] apply_data_reg;

  logic [WIDTH-1:0] value_reg;
  logic             changed_reg, err_reg;

  logic [EW-1:0]    ones_w, mask_w, data_w, value_w;
  logic [EW-1:0]    shift_amt;
  logic [WIDTH-1:0] new_value;
  logic             range_err;

  // Ready depends only on stored occupancy, never on req_valid.
  assign req_ready = (count_reg != 2'd2);
  assign push      = req_valid && req_ready;

  assign value   = value_reg;
  assign changed = changed_reg;
  assign err     = err_reg;
  assign busy    = (count_reg != 2'd0) || (state_reg == APPLY);

  // FIFO entry write on accepted request
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_lsb[wr_ptr_reg]  <= req_lsb;
      fifo_len[wr_ptr_reg]  <= req_len;
      fifo_data[wr_ptr_reg] <= req_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM next state and pop decision
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != 2'd0) begin
          pop        = 1'b1;
          state_next = APPLY;
        end
      end
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the FIFO head into the apply registers when popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      apply_lsb_reg  <= '0;
      apply_len_reg  <= '0;
      apply_data_reg <= '0;
    end else if (pop) begin
      apply_lsb_reg  <= fifo_lsb[rd_ptr_reg];
      apply_len_reg  <= fifo_len[rd_ptr_reg];
      apply_data_reg <= fifo_data[rd_ptr_reg];
    end
  end

  // Masked read-modify-write of the held value, plus range check
  always_comb begin
    shift_amt = {{(EW-LSBW){1'b0}}, apply_len_reg} + EW'(1);
    ones_w    = (EW'(1) << shift_amt) - EW'(1);
    mask_w    = ones_w << apply_lsb_reg;
    data_w    = EW'(apply_data_reg) << apply_lsb_reg;
    value_w   = EW'(value_reg);
    new_value = WIDTH'((value_w & ~mask_w) | (data_w & mask_w));
    range_err = ({1'b0, apply_lsb_reg} + {1'b0, apply_len_reg}) > (LSBW+1)'(WIDTH-1);
  end

  // Commit in APPLY; status pulses are registered alongside the commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_reg   <= RESET_VAL;
      changed_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else if (state_reg == APPLY) begin
      value_reg   <= new_value;
      changed_reg <= (new_value != value_reg);
      err_reg     <= range_err;
    end else begin
      changed_reg <= 1'b0;
      err_reg     <= 1'b0;
    end
  end

`ifdef FIELD_UPDATE_TRACE_EN
  // Trace every commit that alters the register
  always @(posedge clk) begin
    if (!rst && state_reg == APPLY && new_value != value_reg)
      $display("===> %x", new_value);
  end
`endif

endmodule

// File: tb/tb_field_update_engine.sv
// Self-checking bench for field_update_engine: directed test-plan steps
// followed by randomized writes, checked against a bit-level field model.
module tb_field_update_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_lsb = '0;
  logic [2:0] req_len = '0;
  logic [7:0] req_data = '0;
  logic [7:0] value;
  logic       changed, err, busy;

  int total = 0;
  int bad   = 0;

  int changed_cnt = 0, err_cnt = 0, busy_cnt = 0, notready_cnt = 0;
  logic [7:0] model_v;

  field_update_engine #(.WIDTH(8), .LSBW(3), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_lsb(req_lsb), .req_len(req_len), .req_data(req_data),
    .value(value), .changed(changed), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse / occupancy monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (changed)    changed_cnt++;
      if (err)        err_cnt++;
      if (busy)       busy_cnt++;
      if (!req_ready) notready_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sequential field-write semantics, one bit at a time
  function automatic logic [7:0] model_apply(input logic [7:0] v, input int lsb,
                                             input int len, input logic [7:0] d);
    logic [7:0] r = v;
    for (int i = 0; i <= len; i++)
      if (lsb + i < 8) r[lsb + i] = d[i];
    return r;
  endfunction

  // Present a request from a negedge; returns at the negedge after acceptance
  task automatic push(input int lsb, input int len, input logic [7:0] d);
    int guard = 0;
    req_valid = 1'b1;
    req_lsb   = 3'(lsb);
    req_len   = 3'(len);
    req_data  = d;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("push_timeout", 32'(guard), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("idle_timeout", 32'(guard), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // One isolated write: checks value, pulse counts and busy duration
  task automatic do_write(input string tag, input int lsb, input int len, input logic [7:0] d);
    int c0, e0, b0;
    logic [7:0] exp_v;
    c0 = changed_cnt; e0 = err_cnt; b0 = busy_cnt;
    exp_v = model_apply(model_v, lsb, len, d);
    push(lsb, len, d);
    wait_idle();
    check({tag, "_value"}, 32'(value), 32'(exp_v));
    check({tag, "_changed"}, 32'(changed_cnt - c0), (exp_v != model_v) ? 32'd1 : 32'd0);
    check({tag, "_err"}, 32'(err_cnt - e0), (lsb + len > 7) ? 32'd1 : 32'd0);
    check({tag, "_busy2"}, 32'(busy_cnt - b0), 32'd2);
    $display("write %s lsb=%0d len=%0d data=%02h -> value=%02h", tag, lsb, len, d, value);
    model_v = exp_v;
  endtask

  initial begin
    int c0, e0, n_rand;
    logic [7:0] sl;
    model_v = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_value", 32'(value), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_changed", 32'(changed), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Latency of the first write: value appears two edges after acceptance
    push(0, 7, 8'h42);
    check("lat_n1_value", 32'(value), 32'h00);
    @(negedge clk);
    check("lat_n2_value", 32'(value), 32'h00);
    check("lat_n2_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat_n3_value", 32'(value), 32'h42);
    check("lat_n3_changed", 32'(changed), 32'd1);
    check("lat_n3_err", 32'(err), 32'd0);
    @(negedge clk);
    check("lat_n4_changed", 32'(changed), 32'd0);
    wait_idle();
    model_v = 8'h42;
    sl = value;
    check("slice54_a", 32'(sl[5:4]), 32'd0);

    do_write("w2", 3, 2, 8'h07);
    check("w2_const", 32'(value), 32'h7a);
    sl = value;
    check("slice54_b", 32'(sl[5:4]), 32'd3);
    do_write("same", 3, 2, 8'h07);
    do_write("oor", 6, 3, 8'h0f);
    check("oor_const", 32'(value), 32'hfa);

    // Four back-to-back requests, FIFO fills
    c0 = changed_cnt;
    notready_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      push(0, 3, 8'(k));
      model_v = model_apply(model_v, 0, 3, 8'(k));
    end
    wait_idle();
    sl = value;
    check("b2b_nibble", 32'(sl[3:0]), 32'h4);
    check("b2b_value", 32'(value), 32'(model_v));
    check("b2b_changed", 32'(changed_cnt - c0), 32'd4);
    check("b2b_ready_dropped", 32'(notready_cnt > 0), 32'd1);
    $display("b2b done value=%02h notready_cycles=%0d", value, notready_cnt);

    // Randomized stream against the sequential model
    c0 = changed_cnt; e0 = err_cnt;
    begin
      int exp_c = 0, exp_e = 0;
      logic [7:0] nv;
      n_rand = 40;
      for (int k = 0; k < n_rand; k++) begin
        int l, n;
        logic [7:0] d;
        l = int'($urandom_range(7, 0));
        n = int'($urandom_range(7, 0));
        d = 8'($urandom);
        nv = model_apply(model_v, l, n, d);
        if (nv != model_v) exp_c++;
        if (l + n > 7) exp_e++;
        model_v = nv;
        push(l, n, d);
        $display("rand %0d lsb=%0d len=%0d data=%02h model=%02h", k, l, n, d, model_v);
        repeat ($urandom_range(2, 0)) @(negedge clk);
      end
      wait_idle();
      check("rand_value", 32'(value), 32'(model_v));
      check("rand_changed", 32'(changed_cnt - c0), 32'(exp_c));
      check("rand_err", 32'(err_cnt - e0), 32'(exp_e));
    end

    // Reset mid-APPLY with a second request queued
    push(0, 7, 8'h5a);
    push(0, 7, 8'ha5);
    rst = 1'b1;
    #1;
    check("arst_value", 32'(value), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    model_v = 8'h00;
    c0 = changed_cnt; e0 = err_cnt;
    repeat (6) @(negedge clk);
    check("arst_no_changed", 32'(changed_cnt - c0), 32'd0);
    check("arst_no_err", 32'(err_cnt - e0), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd1);
    check("arst_value_hold", 32'(value), 32'h00);
    $display("reset mid-apply value=%02h busy=%0b ready=%0b", value, busy, req_ready);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
